display_scan_mux: RTL and testbench

Time-multiplexing scanner for a 4-digit common-anode 7-segment display. It sits directly upstream of the hex-to-7-segment decoder (4-bit in A, 7-bit out Y). It holds a 16-bit value, walks one nibble at a time onto its A output at a programmable refresh rate, and drives the matching active-low anode enable. Value updates are double-buffered and applied only at frame boundaries, so a frame is never torn. Optional leading-zero blanking.

---
 rtl/display_scan_mux.sv | 102 ++++++++++
 tb/tb_display_scan_mux.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/display_scan_mux.sv
// 4-digit 7-seg scanner: registered outputs switch on the edge the digit index advances.
// Value updates are double-buffered and applied only at the digit 3 -> 0 wrap.
module display_scan_mux #(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  A,
  output logic [3:0]  AN,
  output logic        DP_n,
  output logic        frame_tick
);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [15:0]      r_disp;
  logic [3:0]       r_disp_dp;
  logic [15:0]      r_pend;
  logic [3:0]       r_pend_dp;
  logic             r_pend_vld;

  logic             w_tc;
  logic             w_wrap;
  logic [1:0]       w_idx_nxt;
  logic [15:0]      w_disp_nxt;
  logic [3:0]       w_dp_nxt;
  logic [15:0]      w_shift;
  logic             w_blank;
  logic [3:0]       w_a;
  logic [3:0]       w_an;
  logic             w_dp_n;

  assign w_tc      = (r_cnt == CNT_W'(REFRESH_DIV - 1));
  assign w_wrap    = w_tc && (r_idx == 2'd3);
  assign w_idx_nxt = r_idx + 2'd1;

  // Digit 0 of a new frame must already reflect the pending data it transfers.
  assign w_disp_nxt = (w_wrap && r_pend_vld) ? r_pend    : r_disp;
  assign w_dp_nxt   = (w_wrap && r_pend_vld) ? r_pend_dp : r_disp_dp;
  assign w_shift    = w_disp_nxt >> {w_idx_nxt, 2'b00};

  always_comb begin
    w_blank = 1'b0;
    case (w_idx_nxt)
      2'd1:    w_blank = (w_disp_nxt[15:4]  == 12'h000);
      2'd2:    w_blank = (w_disp_nxt[15:8]  == 8'h00);
      2'd3:    w_blank = (w_disp_nxt[15:12] == 4'h0);
      default: w_blank = 1'b0;
    endcase
    w_blank = w_blank && blank_lz;

    w_a    = w_shift[3:0];
    w_an   = ~(4'b0001 << w_idx_nxt);
    w_dp_n = ~w_dp_nxt[w_idx_nxt];
    if (w_blank) begin
      w_a    = 4'h0;
      w_an   = 4'b1111;
      w_dp_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_idx      <= 2'd0;
      r_disp     <= 16'h0000;
      r_disp_dp  <= 4'h0;
      r_pend     <= 16'h0000;
      r_pend_dp  <= 4'h0;
      r_pend_vld <= 1'b0;
      A          <= 4'h0;
      AN         <= 4'b1110;
      DP_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      r_cnt      <= w_tc ? '0 : r_cnt + CNT_W'(1);
      frame_tick <= w_wrap;
      if (w_tc) begin
        r_idx     <= w_idx_nxt;
        r_disp    <= w_disp_nxt;
        r_disp_dp <= w_dp_nxt;
        A         <= w_a;
        AN        <= w_an;
        DP_n      <= w_dp_n;
      end
      // A load on the wrap edge re-arms the flag after the old pending data moved out.
      if (load) begin
        r_pend     <= value;
        r_pend_dp  <= dp_in;
        r_pend_vld <= 1'b1;
      end else if (w_wrap) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: directed test-plan scenarios plus random loads, checked
// every cycle against a frame-level model derived from elapsed cycles since reset.
module tb_display_scan_mux;
  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, load, blank_lz, rst1;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  A, AN, a1, an1;
  logic        DP_n, frame_tick, dpn1, ft1;

  display_scan_mux #(.REFRESH_DIV(DIV), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .dp_in(dp_in),
    .blank_lz(blank_lz), .A(A), .AN(AN), .DP_n(DP_n), .frame_tick(frame_tick)
  );

  display_scan_mux #(.REFRESH_DIV(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst(rst1), .value(16'h0000), .load(1'b0), .dp_in(4'h0),
    .blank_lz(1'b0), .A(a1), .AN(an1), .DP_n(dpn1), .frame_tick(ft1)
  );

  int          errors = 0;
  int          checks = 0;
  int          m_c, n1;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_dp, m_pdp;
  logic        m_flag;
  logic [3:0]  e_a, e_an;
  logic        e_dpn, e_ft;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, m_c);
    end
  endtask

  task automatic step();
    bit          wrap;
    int          k;
    logic [15:0] sh;
    logic [3:0]  an1_exp;
    @(posedge clk);
    if (rst) begin
      m_c = 0; m_disp = 0; m_pend = 0; m_dp = 0; m_pdp = 0; m_flag = 0;
      e_a = 4'h0; e_an = 4'b1110; e_dpn = 1'b1; e_ft = 1'b0;
    end else begin
      m_c++;
      wrap = (m_c % FRAME) == 0;
      if (wrap && m_flag) begin
        m_disp = m_pend;
        m_dp   = m_pdp;
      end
      if (load) begin
        m_pend = value; m_pdp = dp_in; m_flag = 1'b1;
      end else if (wrap) begin
        m_flag = 1'b0;
      end
      e_ft = wrap;
      if ((m_c % DIV) == 0) begin
        k  = (m_c / DIV) % 4;
        sh = m_disp >> (4 * k);
        if (blank_lz && k >= 1 && sh == 16'h0000) begin
          e_a = 4'h0; e_an = 4'b1111; e_dpn = 1'b1;
        end else begin
          e_a   = sh[3:0];
          e_an  = 4'b1111;
          e_an[k] = 1'b0;
          e_dpn = ~m_dp[k];
        end
      end
    end
    if (rst1) n1 = 0; else n1++;
    #1;
    chk("A", {12'h0, A}, {12'h0, e_a});
    chk("AN", {12'h0, AN}, {12'h0, e_an});
    chk("DP_n", {15'h0, DP_n}, {15'h0, e_dpn});
    chk("frame_tick", {15'h0, frame_tick}, {15'h0, e_ft});
    an1_exp = 4'b1111;
    an1_exp[n1 % 4] = 1'b0;
    chk("div1_AN", {12'h0, an1}, {12'h0, an1_exp});
    chk("div1_tick", {15'h0, ft1}, {15'h0, ((n1 % 4) == 0) && (n1 > 0)});
    chk("div1_A", {12'h0, a1}, 16'h0);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Step until the next step() will be the wrap edge.
  task automatic to_wrap();
    while (((m_c + 1) % FRAME) != 0) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rst1 = 1'b1; load = 1'b0; blank_lz = 1'b0;
    value = 16'h0; dp_in = 4'h0; m_c = 0; n1 = 0;
    run(2);
    rst = 1'b0; rst1 = 1'b0;

    // Reset scan with no load.
    run(2 * FRAME + 3);

    // Load mid-frame, shown from the next wrap.
    to_wrap(); step(); run(5);
    do_load(16'h1A2F, 4'b0100);
    chk("old_frame_A", {12'h0, A}, 16'h0);
    to_wrap(); step();
    chk("ld_d0_A", {12'h0, A}, 16'hF);
    chk("ld_d0_tick", {15'h0, frame_tick}, 16'h1);
    run(DIV);
    chk("ld_d1_A", {12'h0, A}, 16'h2);
    run(DIV);
    chk("ld_d2_A", {12'h0, A}, 16'hA);
    chk("ld_d2_AN", {12'h0, AN}, 16'b1011);
    chk("ld_d2_DP", {15'h0, DP_n}, 16'h0);
    run(DIV);
    chk("ld_d3_A", {12'h0, A}, 16'h1);
    chk("ld_d3_DP", {15'h0, DP_n}, 16'h1);

    // Load coinciding with the wrap edge.
    do_load(16'h1234, 4'h0);
    to_wrap();
    do_load(16'h5678, 4'h0);
    chk("lw_f1_d0", {12'h0, A}, 16'h4);
    run(3 * DIV);
    chk("lw_f1_d3", {12'h0, A}, 16'h1);
    run(DIV);
    chk("lw_f2_d0", {12'h0, A}, 16'h8);
    run(3 * DIV);
    chk("lw_f2_d3", {12'h0, A}, 16'h5);

    // Leading-zero blanking; dp request on a blanked digit stays dark.
    blank_lz = 1'b1;
    do_load(16'h0070, 4'b0100);
    to_wrap(); step();
    chk("lz_d0_AN", {12'h0, AN}, 16'b1110);
    chk("lz_d0_A", {12'h0, A}, 16'h0);
    run(DIV);
    chk("lz_d1_A", {12'h0, A}, 16'h7);
    run(DIV);
    chk("lz_d2_AN", {12'h0, AN}, 16'b1111);
    chk("lz_d2_DP", {15'h0, DP_n}, 16'h1);
    run(DIV);
    chk("lz_d3_AN", {12'h0, AN}, 16'b1111);
    do_load(16'h0000, 4'h0);
    to_wrap(); step();
    chk("lz0_d0_AN", {12'h0, AN}, 16'b1110);
    run(DIV);
    chk("lz0_d1_AN", {12'h0, AN}, 16'b1111);
    blank_lz = 1'b0;

    // Reset during digit 2 with a pending load outstanding.
    to_wrap(); step(); run(2 * DIV);
    do_load(16'hBEEF, 4'hF);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_AN", {12'h0, AN}, 16'b1110);
    chk("rst_A", {12'h0, A}, 16'h0);
    run(3 * FRAME);

    // Random traffic.
    for (int i = 0; i < 1200; i++) begin
      load  = ($urandom % 12) == 0;
      value = 16'($urandom);
      if (($urandom % 3) == 0) value[15:8] = 8'h00;
      dp_in = 4'($urandom);
      if (($urandom % 40) == 0) blank_lz = ~blank_lz;
      rst = ($urandom % 250) == 0;
      step();
    end
    load = 1'b0; rst = 1'b0;
    run(FRAME);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
